// File: rtl/cmos_capture.sv
// DVP-style CMOS sensor capture: assembles RGB565 pixels from byte pairs,
// tracks x/y position and flags frame/line geometry errors.
module cmos_capture #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SKIP_FRAMES = 2
) (
   input  logic        cmos_pclk,
   input  logic        rst,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_db,
   input  logic        capture_en,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        frame_start,
   output logic        frame_done,
   output logic        line_err
);

   typedef enum logic [1:0] {SKIP = 2'd0, WAIT_FRAME = 2'd1, ACTIVE = 2'd2} state_t;

   localparam logic [9:0] H_LIM    = 10'(H_ACTIVE);
   localparam logic [8:0] V_LIM    = 9'(V_ACTIVE);
   localparam logic [7:0] SKIP_LIM = 8'(SKIP_FRAMES);

   state_t      state_q, state_d;
   logic        vs_q, vs_d, hr_q, hr_d, vs_p_q, vs_p_d, hr_p_q, hr_p_d;
   logic [7:0]  db_q, db_d, hi_q, hi_d, skip_q, skip_d;
   logic [9:0]  x_q, x_d, px_q, px_d, pix_x_q, pix_x_d;
   logic [8:0]  y_q, y_d, py_q, py_d, pix_y_q, pix_y_d;
   logic        ph_q, ph_d, pv_q, pv_d;
   logic [15:0] pd_q, pd_d, pix_data_q, pix_data_d;
   logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
   logic        frame_done_q, frame_done_d, line_err_q, line_err_d;
   logic        vs_rise, vs_fall, hr_fall;

   assign vs_rise = vs_q & ~vs_p_q;
   assign vs_fall = ~vs_q & vs_p_q;
   assign hr_fall = ~hr_q & hr_p_q;

   always_comb begin
      state_d       = state_q;
      vs_d          = cmos_vsync;
      hr_d          = cmos_href;
      db_d          = cmos_db;
      vs_p_d        = vs_q;
      hr_p_d        = hr_q;
      hi_d          = hi_q;
      skip_d        = skip_q;
      x_d           = x_q;
      y_d           = y_q;
      ph_d          = ph_q;
      pv_d          = 1'b0;
      pd_d          = pd_q;
      px_d          = px_q;
      py_d          = py_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      line_err_d    = line_err_q;
      // Second stage: staged pixel moves to the outputs, which hold otherwise.
      pix_valid_d   = pv_q;
      pix_data_d    = pv_q ? pd_q : pix_data_q;
      pix_x_d       = pv_q ? px_q : pix_x_q;
      pix_y_d       = pv_q ? py_q : pix_y_q;

      case (state_q)
         SKIP: begin
            if (vs_rise) skip_d = skip_q + 8'd1;
            if (skip_d >= SKIP_LIM) state_d = WAIT_FRAME;
         end
         WAIT_FRAME: begin
            if (vs_fall && capture_en) begin
               state_d       = ACTIVE;
               frame_start_d = 1'b1;
               x_d           = '0;
               y_d           = '0;
               ph_d          = 1'b0;
            end
         end
         ACTIVE: begin
            // Frame end outranks any byte arriving on the same cycle.
            if (vs_rise) begin
               frame_done_d = 1'b1;
               if (y_q != V_LIM) line_err_d = 1'b1;
               ph_d    = 1'b0;
               state_d = WAIT_FRAME;
            end else if (hr_q) begin
               if (!ph_q) begin
                  hi_d = db_q;
                  ph_d = 1'b1;
               end else begin
                  ph_d = 1'b0;
                  x_d  = (x_q == 10'h3ff) ? x_q : x_q + 10'd1;
                  if (x_q < H_LIM && y_q < V_LIM) begin
                     pv_d = 1'b1;
                     pd_d = {hi_q, db_q};
                     px_d = x_q;
                     py_d = y_q;
                  end else begin
                     line_err_d = 1'b1;
                  end
               end
            end else if (hr_fall) begin
               if (x_q != H_LIM || ph_q) line_err_d = 1'b1;
               x_d  = '0;
               ph_d = 1'b0;
               y_d  = (y_q == 9'h1ff) ? y_q : y_q + 9'd1;
            end
         end
         default: state_d = SKIP;
      endcase
   end

   always_ff @(posedge cmos_pclk or posedge rst) begin
      if (rst) begin
         state_q       <= SKIP;
         vs_q          <= 1'b0;
         hr_q          <= 1'b0;
         db_q          <= '0;
         vs_p_q        <= 1'b0;
         hr_p_q        <= 1'b0;
         hi_q          <= '0;
         skip_q        <= '0;
         x_q           <= '0;
         y_q           <= '0;
         ph_q          <= 1'b0;
         pv_q          <= 1'b0;
         pd_q          <= '0;
         px_q          <= '0;
         py_q          <= '0;
         pix_valid_q   <= 1'b0;
         pix_data_q    <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         line_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         vs_q          <= vs_d;
         hr_q          <= hr_d;
         db_q          <= db_d;
         vs_p_q        <= vs_p_d;
         hr_p_q        <= hr_p_d;
         hi_q          <= hi_d;
         skip_q        <= skip_d;
         x_q           <= x_d;
         y_q           <= y_d;
         ph_q          <= ph_d;
         pv_q          <= pv_d;
         pd_q          <= pd_d;
         px_q          <= px_d;
         py_q          <= py_d;
         pix_valid_q   <= pix_valid_d;
         pix_data_q    <= pix_data_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         line_err_q    <= line_err_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_data    = pix_data_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign line_err    = line_err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Randomized bench for cmos_capture: a frame-level model predicts every pixel,
// its arrival cycle, frame pulse counts and the sticky error flag.
module tb_cmos_capture;

   localparam int H = 4;
   localparam int V = 2;
   localparam int SKIP = 1;

   typedef struct {
      logic [15:0] d;
      int          x;
      int          y;
      int          c;
   } pix_t;

   logic        cmos_pclk = 1'b0;
   logic        rst = 1'b0;
   logic        cmos_vsync = 1'b0;
   logic        cmos_href = 1'b0;
   logic [7:0]  cmos_db = '0;
   logic        capture_en = 1'b0;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        frame_start, frame_done, line_err;

   int   n_vec = 0, n_err = 0, cyc = 0;
   int   rises = 0, exp_starts = 0, exp_dones = 0, obs_starts = 0, obs_dones = 0;
   bit   exp_err = 0, cap_en = 1;
   pix_t q[$];
   pix_t e;
   logic [15:0] hd = '0;
   int   hx = 0, hy = 0;

   cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP)) dut (
      .cmos_pclk(cmos_pclk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
      .cmos_db(cmos_db), .capture_en(capture_en), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .frame_done(frame_done),
      .line_err(line_err)
   );

   always #5 cmos_pclk = ~cmos_pclk;
   always @(posedge cmos_pclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge cmos_pclk);
      #1;
   endtask

   // Pixel monitor: each strobe must match the oldest predicted pixel.
   always @(negedge cmos_pclk) begin
      if (rst) begin
         q.delete();
         hd = '0; hx = 0; hy = 0;
      end else begin
         if (frame_start) obs_starts++;
         if (frame_done)  obs_dones++;
         if (pix_valid) begin
            if (q.size() == 0) chk("spurious_pix", 1, 0);
            else begin
               e = q.pop_front();
               chk("pix_data", pix_data, e.d);
               chk("pix_x", pix_x, e.x);
               chk("pix_y", pix_y, e.y);
               chk("pix_latency", cyc, e.c);
               hd = e.d; hx = e.x; hy = e.y;
            end
         end else begin
            chk("hold_data", pix_data, hd);
            chk("hold_x", pix_x, hx);
            chk("hold_y", pix_y, hy);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", pix_valid, 0);
      chk("rst_data", pix_data, 0);
      chk("rst_x", pix_x, 0);
      chk("rst_y", pix_y, 0);
      chk("rst_fstart", frame_start, 0);
      chk("rst_fdone", frame_done, 0);
      chk("rst_err", line_err, 0);
      cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_db = '0;
      rises = 0; exp_err = 0;
      repeat (3) @(posedge cmos_pclk);
      #1;
      rst = 1'b0;
      repeat (2) tick();
   endtask

   // One frame: vsync low, nl lines of href bytes, then vsync high blanking.
   // abort_n >= 0 ends the last line after abort_n bytes by raising vsync with href high.
   task automatic send_frame(input int nl, input int l0, input int l1, input int l2,
                             input bit fixed, input int abort_n, input bit drop_en);
      int lens[3];
      bit cap, aborted;
      logic [7:0] b, hi;
      int seq, cnt;
      pix_t p;
      lens = '{l0, l1, l2};
      seq = 1; aborted = 0; hi = '0;
      cap = (cmos_vsync == 1'b1) && (rises >= SKIP) && cap_en;
      capture_en = cap_en; cmos_vsync = 1'b0; cmos_href = 1'b0;
      if (cap) exp_starts++;
      repeat (3) tick();
      for (int l = 0; l < nl && !aborted; l++) begin
         cnt = (l == nl - 1 && abort_n >= 0) ? abort_n : lens[l];
         for (int i = 0; i < cnt; i++) begin
            b = fixed ? 8'(seq) : 8'($urandom);
            seq++;
            cmos_href = 1'b1; cmos_db = b;
            if (i % 2 == 0) hi = b;
            else if (cap) begin
               if (i / 2 < H && l < V) begin
                  p.d = {hi, b}; p.x = i / 2; p.y = l; p.c = cyc + 3;
                  q.push_back(p);
               end else exp_err = 1;
            end
            tick();
         end
         if (l == nl - 1 && abort_n >= 0) begin
            cmos_vsync = 1'b1; cmos_db = 8'($urandom);
            tick();
            cmos_href = 1'b0; aborted = 1; rises++;
            if (cap) begin
               exp_dones++;
               if (l != V) exp_err = 1;
            end
         end else begin
            cmos_href = 1'b0;
            if (cap && cnt != 2 * H) exp_err = 1;
            repeat (3) tick();
         end
         if (drop_en) capture_en = 1'b0;
      end
      if (!aborted) begin
         cmos_vsync = 1'b1; rises++;
         if (cap) begin
            exp_dones++;
            if (nl != V) exp_err = 1;
         end
      end
      repeat (5) tick();
      chk("q_empty", q.size(), 0);
      chk("frame_starts", obs_starts, exp_starts);
      chk("frame_dones", obs_dones, exp_dones);
      chk("line_err", line_err, exp_err);
   endtask

   function automatic int pick_len();
      case ($urandom_range(0, 5))
         3:       return 6;
         4:       return 10;
         5:       return 5;
         default: return 8;
      endcase
   endfunction

   initial begin
      #400000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      pix_t p;
      logic [7:0] b, hi;
      #1;
      do_reset();
      send_frame(2, 8, 8, 0, 0, -1, 0);       // settling frame, discarded
      send_frame(2, 8, 8, 0, 1, -1, 0);       // bytes 01..10
      send_frame(2, 8, 8, 0, 0, -1, 1);       // capture_en dropped mid-frame
      cap_en = 0;
      send_frame(2, 8, 8, 0, 0, -1, 0);       // gated off
      cap_en = 1;
      send_frame(2, 8, 8, 0, 0, -1, 0);
      send_frame(2, 5, 8, 0, 0, -1, 0);       // short odd line

      // reset in the middle of a captured line
      capture_en = 1'b1; cmos_vsync = 1'b0; exp_starts++;
      repeat (3) tick();
      hi = '0;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         cmos_href = 1'b1; cmos_db = b;
         if (i % 2 == 0) hi = b;
         else begin
            p.d = {hi, b}; p.x = i / 2; p.y = 0; p.c = cyc + 3;
            q.push_back(p);
         end
         tick();
      end
      do_reset();
      send_frame(2, 8, 8, 0, 0, -1, 0);       // discarded after reset
      send_frame(2, 8, 8, 0, 0, -1, 0);
      send_frame(2, 10, 8, 0, 0, -1, 0);      // long line, fifth pixel dropped
      do_reset();
      send_frame(2, 8, 8, 0, 0, -1, 0);
      send_frame(2, 8, 3, 0, 0, 3, 0);        // vsync rises with href high
      send_frame(2, 8, 8, 0, 0, -1, 0);
      do_reset();
      send_frame(1, 8, 0, 0, 0, -1, 0);
      for (int f = 0; f < 8; f++) begin
         cap_en = ($urandom_range(0, 3) != 0);
         send_frame($urandom_range(1, 3), pick_len(), pick_len(), pick_len(), 0,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cmos_capture.md
CMOS_CAPTURE -- requirements
Module: cmos_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: pixels per active line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter SKIP_FRAMES, default 2: complete frames discarded after reset, for sensor settling.
REQ-004 cmos_pclk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cmos_vsync  input  1  high = vertical blanking.
REQ-007 cmos_href  input  1  high = active line bytes on cmos_db.
REQ-008 cmos_db  input  8  sensor byte; two bytes per RGB565 pixel, first byte first.
REQ-009 capture_en  input  1  permits a new frame to start.
REQ-010 pix_data  output  16  RGB565 pixel; first byte in [15:8], second byte in [7:0].
REQ-011 pix_valid  output  1  one-cycle strobe qualifying pix_data/pix_x/pix_y.
REQ-012 pix_x  output  10  column of current pixel, 0..H_ACTIVE-1.
REQ-013 pix_y  output  9  row of current pixel, 0..V_ACTIVE-1.
REQ-014 frame_start  output  1  one-cycle pulse when a captured frame begins.
REQ-015 frame_done  output  1  one-cycle pulse when a captured frame ends.
REQ-016 line_err  output  1  sticky geometry-error flag.

Function
REQ-017 cmos_vsync, cmos_href, cmos_db SHALL be registered once (vs_q, hr_q, db_q); all decisions use registered copies only.
REQ-018 States SHALL be SKIP, WAIT_FRAME, ACTIVE; reset enters SKIP with skip counter 0.
REQ-019 SKIP: skip counter increments on each vs_q rising edge; on reaching SKIP_FRAMES, go to WAIT_FRAME; SKIP_FRAMES=0 goes to WAIT_FRAME on the first post-reset edge.
REQ-020 WAIT_FRAME: vs_q falling edge with capture_en=1 -> ACTIVE, frame_start pulse same cycle, x=0, y=0, byte phase=0; with capture_en=0 stay in WAIT_FRAME.
REQ-021 ACTIVE, hr_q=1, phase 0: latch db_q as high byte, phase->1.
REQ-022 ACTIVE, hr_q=1, phase 1: pix_data={high byte, db_q}, pix_x=x, pix_y=y, pix_valid=1 on the next edge, x increments, phase->0.
REQ-023 Latency: second byte present on cmos_db at edge N -> pix_valid high for the cycle following edge N+2.
REQ-024 Pixels with x >= H_ACTIVE or y >= V_ACTIVE SHALL be dropped (no pix_valid) and set line_err.
REQ-025 hr_q falling edge in ACTIVE: if x != H_ACTIVE or phase=1, set line_err; then x=0, phase=0, y increments (saturating at 511).
REQ-026 vs_q rising edge in ACTIVE: frame_done pulse; if y != V_ACTIVE set line_err; -> WAIT_FRAME.
REQ-027 vs_q rising edge coincident with hr_q=1: frame end wins; any half pixel discarded, no pix_valid.
REQ-028 capture_en deassertion during ACTIVE SHALL NOT abort the frame; it gates only the next start.
REQ-029 pix_data, pix_x, pix_y SHALL hold last values while pix_valid=0.
REQ-030 line_err SHALL remain set until reset.

Reset
REQ-031 On rst: all outputs 0, state SKIP, all counters/phase/input registers 0, asynchronously.
REQ-032 rst mid-frame aborts capture; no frame_done is produced for the aborted frame.

Verification (H_ACTIVE=4, V_ACTIVE=2, SKIP_FRAMES=1)
REQ-033 Reset, one full frame, then frame of bytes 01..10 -> first frame silent; second: frame_start once, pix_data 0102,0304,...,0F10, (x,y) (0,0)..(3,1), frame_done once, line_err=0.
REQ-034 Line of 5 bytes -> pixels 0..1 valid; line_err=1 at href fall; next line starts at x=0.
REQ-035 Line of 10 bytes -> 4 pixels valid, fifth dropped, line_err=1.
REQ-036 capture_en=0 at vsync fall -> no frame_start, no pix_valid for that frame; capture_en=1 next frame -> normal capture.
REQ-037 vsync rises while href high after 3 bytes of line 1 -> frame_done pulse, third byte dropped, line_err=1.
REQ-038 rst asserted mid-line -> outputs 0 immediately; after release, SKIP_FRAMES frames discarded before next frame_start.
